// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle,
// operating on operand magnitudes with the sign fixed up in a final cycle.
module muldiv_unit #(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e              state_q;
    logic                ready_q, busy_q, done_q;
    logic [XLEN-1:0]     result_q;
    logic [CNTW-1:0]     cnt_q;
    logic [2:0]          op_q;
    logic                neg_q;   // sign(a)^sign(b): negate product / quotient
    logic                sa_q;    // sign(a): negate remainder
    logic [XLEN-1:0]     opd_q;   // multiplicand magnitude or divisor magnitude
    // Multiply: {hi, lo} product accumulator, lo starts as the multiplier.
    // Divide: lo half holds dividend bits shifting out / quotient bits in.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN:0]       rem_q;   // partial remainder

    // Accept-time decode
    logic                is_div, a_sgn, b_sgn, sa, sb, b_zero, ovf, special;
    logic [XLEN-1:0]     mag_a, mag_b, special_res;
    // Per-iteration and fix-up datapath
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_acc_d;
    logic [XLEN+1:0]     div_diff;
    logic [XLEN:0]       div_rem_d;
    logic [XLEN-1:0]     div_quo_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

    // Operand decode: signedness, magnitudes and the division special cases
    always_comb begin
        is_div      = funct3[2];
        // signed a: MUL, MULH, MULHSU, DIV, REM; signed b: MUL, MULH, DIV, REM
        a_sgn       = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn       = is_div ? ~funct3[0] : ~funct3[1];
        sa          = a_sgn & a[XLEN-1];
        sb          = b_sgn & b[XLEN-1];
        mag_a       = sa ? (~a + 1'b1) : a;
        mag_b       = sb ? (~b + 1'b1) : b;
        b_zero      = (b == '0);
        ovf         = ~funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special     = is_div & (b_zero | ovf);
        special_res = '0;
        if (b_zero)
            special_res = funct3[1] ? a : '1;
        else if (ovf)
            special_res = funct3[1] ? '0 : a;
    end

    // One shift-add / restoring-subtract step plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
        // rem_q[XLEN] is always 0 here, so the top bit of div_diff is the borrow
        div_diff  = {rem_q, acc_q[XLEN-1]} - {2'b00, opd_q};
        div_rem_d = div_diff[XLEN+1] ? {rem_q[XLEN-1:0], acc_q[XLEN-1]} : div_diff[XLEN:0];
        div_quo_d = {acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = sa_q  ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    // Control FSM and datapath registers; kill overrides every transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        op_q    <= funct3;
                        neg_q   <= sa ^ sb;
                        sa_q    <= sa;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        opd_q   <= is_div ? mag_b : mag_a;
                        acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (op_q[2]) begin
                            acc_q <= {acc_q[2*XLEN-1:XLEN], div_quo_d};
                            rem_q <= div_rem_d;
                        end else begin
                            acc_q <= mul_acc_d;
                        end
                        if (cnt_q == CNTW'(XLEN-1))
                            state_q <= S_FIX;
                    end
                    S_FIX: begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at XLEN=32 and XLEN=64.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        start32 = 1'b0, start64 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic [63:0] a64 = '0, b64 = '0, res64;
    logic        ready32, busy32, done32, ready64, busy64, done64;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) u32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .kill(kill), .funct3(funct3),
        .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_unit #(.XLEN(64)) u64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .kill(kill), .funct3(funct3),
        .a(a64), .b(b64), .ready(ready64), .busy(busy64), .done(done64), .result(res64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency from start, check result, handshake, one-cycle done
    task automatic do_op(input bit w64, input logic [2:0] f, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] exp,
                         input int exp_lat, input string tag);
        int n;
        bit hs_bad;
        @(negedge clk);
        funct3 = f;
        if (w64) begin a64 = av; b64 = bv; start64 = 1'b1; end
        else     begin a32 = av[31:0]; b32 = bv[31:0]; start32 = 1'b1; end
        @(posedge clk); #1;
        start32 = 1'b0; start64 = 1'b0;
        a32 = '1; b32 = '1; a64 = '1; b64 = '1;   // operands are don't-care now
        n = 1;
        hs_bad = 1'b0;
        while (!(w64 ? done64 : done32) && n < 200) begin
            if ((w64 ? ready64 : ready32) || !(w64 ? busy64 : busy32)) hs_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, w64 ? res64 : {32'h0, res32}, exp);
        chk({tag, "_hs"}, 64'(hs_bad), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done1"}, 64'(w64 ? done64 : done32), 64'd0);
        chk({tag, "_rdy"}, 64'(w64 ? ready64 : ready32), 64'd1);
    endtask

    initial begin
        int n;
        bit saw_done;

        // reset state
        #12;
        chk("rst_ready", 64'(ready32), 64'd1);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_result", {32'h0, res32}, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // multiply family
        do_op(0, 3'b000, 64'h7, 64'hFFFFFFFD, 64'hFFFFFFEB, 34, "mul");
        do_op(0, 3'b001, 64'h80000000, 64'h80000000, 64'h40000000, 34, "mulh");
        do_op(0, 3'b011, 64'h80000000, 64'h80000000, 64'h40000000, 34, "mulhu");
        do_op(0, 3'b010, 64'h80000000, 64'h80000000, 64'hC0000000, 34, "mulhsu");

        // divide family
        do_op(0, 3'b100, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 34, "div");
        do_op(0, 3'b110, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFF, 34, "rem");
        do_op(0, 3'b101, 64'hFFFFFFF9, 64'h2, 64'h7FFFFFFC, 34, "divu");

        // division special cases: one-cycle turnaround
        do_op(0, 3'b100, 64'h1234, 64'h0, 64'hFFFFFFFF, 1, "div0");
        do_op(0, 3'b101, 64'h1234, 64'h0, 64'hFFFFFFFF, 1, "divu0");
        do_op(0, 3'b110, 64'h1234, 64'h0, 64'h1234, 1, "rem0");
        do_op(0, 3'b111, 64'h1234, 64'h0, 64'h1234, 1, "remu0");
        do_op(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, "div_ovf");
        do_op(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h0, 1, "rem_ovf");

        // kill at CALC cycle 10: no done, result untouched (prior result is 0)
        @(negedge clk);
        funct3 = 3'b000; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", 64'(ready32), 64'd1);
        chk("kill_busy", 64'(busy32), 64'd0);
        chk("kill_result", {32'h0, res32}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) saw_done = 1'b1;
        end
        chk("kill_nodone", 64'(saw_done), 64'd0);

        // kill together with start in IDLE is not accepted
        @(negedge clk);
        funct3 = 3'b000; a32 = 32'd3; b32 = 32'd3; start32 = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; kill = 1'b0;
        chk("killstart_ready", 64'(ready32), 64'd1);
        chk("killstart_busy", 64'(busy32), 64'd0);

        do_op(0, 3'b000, 64'd6, 64'd7, 64'd42, 34, "post_kill");

        // asynchronous reset mid-CALC, between clock edges
        @(negedge clk);
        funct3 = 3'b000; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", 64'(ready32), 64'd1);
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_done", 64'(done32), 64'd0);
        chk("arst_result", {32'h0, res32}, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        do_op(0, 3'b101, 64'd100, 64'd7, 64'd14, 34, "divu_100_7");
        do_op(0, 3'b111, 64'd100, 64'd7, 64'd2, 34, "remu_100_7");

        // XLEN=64 instance
        do_op(1, 3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 66, "mul64");
        do_op(1, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 66, "mulhu64");
        do_op(1, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 66, "div64");
        do_op(1, 3'b110, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, "rem_ovf64");

        n = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
